// File: rtl/uart_rx_pkg.sv
// Shared types and sizing helpers for the UART receive sequencer.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    LOAD
  } rx_state_t;

  // Bit-period counter width: must be able to hold CLKS_PER_BIT itself.
  function automatic int cnt_width(input int clks_per_bit);
    return $clog2(clks_per_bit + 1);
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period counter for the UART receiver. Counts while enabled and
// pulses sample_tick_o for one cycle when tc_i cycles have elapsed since
// the last clear or tick, then wraps to zero.
module rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_i,
  output logic             sample_tick_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sample_tick_o = en_i && (cnt_q == (tc_i - CNT_W'(1)));

  // Next count: clear dominates, wrap to zero on the sample tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (sample_tick_o) cnt_d = '0;
      else               cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises the line, finds the start bit,
// samples mid-bit, assembles an LSB-first frame, checks the stop bit and
// hands the byte to the host with a ready/read handshake.
// Optional even-parity checking is compiled in with PARITY_CHECK_EN.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int BC_W  = $clog2(DATA_BITS + 1);

  rx_state_t            state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [BC_W-1:0]      bitcnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 ready_q, overrun_q, framing_q;
  logic                 tick;
  logic [CNT_W-1:0]     tc;
  logic                 fall;
  logic                 last_bit;

  assign fall     = prev_q && !sync2_q;
  assign last_bit = (bitcnt_q == BC_W'(DATA_BITS - 1));
  assign tc       = (state_q == START) ? CNT_W'(HALF) : CNT_W'(CLKS_PER_BIT);

  rx_bit_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (state_q == IDLE),
    .en_i         ((state_q != IDLE) && (state_q != LOAD)),
    .tc_i         (tc),
    .sample_tick_o(tick)
  );

  // Two-flop synchroniser plus the edge-detect flop; line idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; every decision beyond IDLE waits for a sample tick.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (fall) state_d = START;
      START:  if (tick) state_d = sync2_q ? IDLE : DATA;
`ifdef PARITY_CHECK_EN
      DATA:   if (tick && last_bit) state_d = PARITY;
`else
      DATA:   if (tick && last_bit) state_d = STOP;
`endif
      PARITY: if (tick) state_d = STOP;
      STOP:   if (tick) state_d = sync2_q ? LOAD : IDLE;
      LOAD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit counter: cleared in START, counts sampled data bits up to DATA_BITS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt_q <= '0;
    end else if (state_q == START) begin
      bitcnt_q <= '0;
    end else if ((state_q == DATA) && tick) begin
      bitcnt_q <= bitcnt_q + BC_W'(1);
    end
  end

  // Shift register: new bit enters at the MSB so the first bit ends at the LSB.
  always_ff @(posedge clk) begin
    if ((state_q == DATA) && tick) shift_q <= {sync2_q, shift_q[DATA_BITS-1:1]};
  end

`ifdef PARITY_CHECK_EN
  logic par_bit_q;
  logic parity_q;

  // Capture the received parity bit.
  always_ff @(posedge clk) begin
    if ((state_q == PARITY) && tick) par_bit_q <= sync2_q;
  end

  // Parity flag, updated only when a frame is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  parity_q <= 1'b0;
    else if (state_q == LOAD) parity_q <= (^shift_q) ^ par_bit_q;
  end

  assign parity_error = parity_q;
`else
  assign parity_error = 1'b0;
`endif

  // Host-facing data and flags; a load takes priority over a coincident read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      framing_q <= 1'b0;
    end else if (state_q == LOAD) begin
      rx_data_q <= shift_q;
      ready_q   <= 1'b1;
      overrun_q <= ready_q && !data_read;
      framing_q <= 1'b0;
    end else begin
      if ((state_q == STOP) && tick && !sync2_q) framing_q <= 1'b1;
      if (data_read) begin
        ready_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign rx_data       = rx_data_q;
  assign data_ready    = ready_q;
  assign overrun_error = overrun_q;
  assign framing_error = framing_q;
  assign busy          = (state_q != IDLE);

endmodule
